// File: rtl/axi4_lite_rr_master_arbiter_if.sv
// AXI4-Lite master-side bundle (AW, W, AR, R; no B) shared by the round-robin arbiter.
interface axi4_lite_rr_master_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA,  WVALID,  input WREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA,  RVALID,  output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA,  WVALID,  output WREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA,  RVALID,  input  RREADY
    );
endinterface

// File: rtl/axi4_lite_rr_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among NUM_REQ requesters,
// one transaction in flight; writes finish on AW+W acceptance, reads on R acceptance.
module axi4_lite_rr_master_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          busy,
    axi4_lite_rr_master_arbiter_if.master m_axi
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic                  found;
    logic [IDX_W-1:0]      pick;
    logic [IDX_W-1:0]      cand;

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First pending requester strictly after last_q, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = IDX_W'((int'(last_q) + k) % int'(NUM_REQ));
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                if (found && !ARESET) begin
                    req_ready[pick] = 1'b1;
                    sel_d           = pick;
                    last_d          = pick;
                    addr_d          = addr_arr[pick];
                    wdata_d         = wdata_arr[pick];
                    if (req_write[pick]) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                awvalid_d = awvalid_q & ~m_axi.AWREADY;
                wvalid_d  = wvalid_q & ~m_axi.WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    rsp_valid_d[sel_q] = 1'b1;
                    state_d            = IDLE;
                end
            end
            RD: begin
                if (arvalid_q && m_axi.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (rready_q && m_axi.RVALID) begin
                    rready_d           = 1'b0;
                    rsp_rdata_d        = m_axi.RDATA;
                    rsp_valid_d[sel_q] = 1'b1;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign m_axi.AWADDR  = addr_q;
    assign m_axi.AWVALID = awvalid_q;
    assign m_axi.WDATA   = wdata_q;
    assign m_axi.WVALID  = wvalid_q;
    assign m_axi.ARADDR  = addr_q;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = rready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_axi4_lite_rr_master_arbiter.sv
// Directed bench for the AXI4-Lite round-robin arbiter: vector table plus reset,
// fairness and abort sequences against a delay-programmable slave.
module tb_axi4_lite_rr_master_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0]       req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0]    req_addr;
    logic [NR*DW-1:0]    req_wdata;
    logic [DW-1:0]       rsp_rdata;
    logic                busy;

    axi4_lite_rr_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi4_lite_rr_master_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(clk), .ARESET(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .busy(busy),
        .m_axi(axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rsp_seen = 0;

    // Slave: each READY rises after its VALID has been up for *_dly cycles;
    // RVALID rises r_dly+1 cycles after the AR handshake cycle.
    int aw_dly, w_dly, ar_dly, r_dly;
    int aw_cnt, w_cnt, ar_cnt, r_wait;
    bit ar_hs_last, r_hs_last;
    logic [DW-1:0] r_data_val;

    initial begin
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.ARREADY = 1'b0;
        axi.RVALID = 1'b0;  axi.RDATA = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_wait = -1;
        ar_hs_last = 1'b0; r_hs_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.ARREADY = 1'b0;
                axi.RVALID = 1'b0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_wait = -1;
                ar_hs_last = 1'b0; r_hs_last = 1'b0;
            end else begin
                if (r_hs_last) axi.RVALID = 1'b0;
                if (ar_hs_last) r_wait = r_dly;
                if (r_wait == 0) begin
                    axi.RVALID = 1'b1;
                    axi.RDATA  = r_data_val;
                    r_wait     = -1;
                end else if (r_wait > 0) begin
                    r_wait--;
                end
                if (axi.AWVALID) begin axi.AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin axi.AWREADY = 1'b0; aw_cnt = 0; end
                if (axi.WVALID) begin axi.WREADY = (w_cnt >= w_dly); w_cnt++; end
                else begin axi.WREADY = 1'b0; w_cnt = 0; end
                if (axi.ARVALID) begin axi.ARREADY = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin axi.ARREADY = 1'b0; ar_cnt = 0; end
                ar_hs_last = axi.ARVALID && axi.ARREADY;
                r_hs_last  = axi.RVALID && axi.RREADY;
            end
        end
    end

    typedef struct {
        bit          wr;
        int          idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_d, w_d, ar_d, r_d;
        logic [31:0] rdata;
        int          lat, awc, wc, arc;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        if (|rsp_valid) rsp_seen++;
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < int'(NR); i++)
            if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    task automatic wait_grant(input int bound, output int g);
        g = -1;
        for (int c = 0; c < bound; c++) begin
            if (req_ready != '0) begin
                g = oh_idx(req_ready);
                break;
            end
            tick();
        end
    endtask

    task automatic run_vec(input int n);
        vec_t v;
        int g, lat, awc, wc, arc, bad, viol, base, busy1;
        logic [NR-1:0] rv;
        logic [DW-1:0] rd;
        v = vecs[n];
        aw_dly = v.aw_d; w_dly = v.w_d; ar_dly = v.ar_d; r_dly = v.r_d;
        r_data_val = v.rdata;
        req_valid = '0; req_write = '0;
        req_valid[v.idx] = 1'b1;
        req_write[v.idx] = v.wr;
        req_addr[v.idx*AW +: AW]  = v.addr;
        req_wdata[v.idx*DW +: DW] = v.wdata;
        #1;
        wait_grant(20, g);
        chk($sformatf("v%0d_grant", n), 64'(g), 64'(v.idx));
        base = rsp_seen;
        lat = -1; awc = 0; wc = 0; arc = 0; bad = 0; viol = 0; busy1 = 0;
        rv = '0; rd = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) begin
                req_valid = '0;
                busy1 = int'(busy);
            end
            if (axi.AWVALID) begin awc++; if (axi.AWADDR !== v.addr)  bad++; end
            if (axi.WVALID)  begin wc++;  if (axi.WDATA  !== v.wdata) bad++; end
            if (axi.ARVALID) begin arc++; if (axi.ARADDR !== v.addr)  bad++; end
            if (axi.RREADY && (axi.ARVALID || v.wr)) viol++;
            if ((|rsp_valid) && lat < 0) begin
                lat = c; rv = rsp_valid; rd = rsp_rdata;
            end
            if (lat >= 0 && c >= lat + 2) break;
        end
        chk($sformatf("v%0d_busy", n),     64'(busy1), 64'd1);
        chk($sformatf("v%0d_latency", n),  64'(lat), 64'(v.lat));
        chk($sformatf("v%0d_awv_cyc", n),  64'(awc), 64'(v.awc));
        chk($sformatf("v%0d_wv_cyc", n),   64'(wc),  64'(v.wc));
        chk($sformatf("v%0d_arv_cyc", n),  64'(arc), 64'(v.arc));
        chk($sformatf("v%0d_payload", n),  64'(bad), 64'd0);
        chk($sformatf("v%0d_rready", n),   64'(viol), 64'd0);
        chk($sformatf("v%0d_rsp_vec", n),  64'(rv), 64'(NR'(1) << v.idx));
        chk($sformatf("v%0d_rsp_cnt", n),  64'(rsp_seen - base), 64'd1);
        chk($sformatf("v%0d_rdata", n),    64'(rd), 64'(v.exp_rdata));
        chk($sformatf("v%0d_idle", n),     64'(busy), 64'd0);
    endtask

    initial begin
        int g, ng, prev, base;
        int exp_rr [5];
        exp_rr = '{0, 1, 2, 3, 0};

        //        wr idx addr          wdata          aw w ar r rdata          lat awc wc arc exp_rdata
        vecs[0] = '{1, 2, 32'h10,       32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        2, 1, 1, 0, 32'h0};
        vecs[1] = '{0, 1, 32'h24,       32'h0,        0, 0, 3, 1, 32'h12345678, 7, 0, 0, 4, 32'h12345678};
        vecs[2] = '{1, 0, 32'h40,       32'h000055AA, 4, 0, 0, 0, 32'h0,        6, 5, 1, 0, 32'h12345678};
        vecs[3] = '{1, 3, 32'h44,       32'h11112222, 0, 2, 0, 0, 32'h0,        4, 1, 3, 0, 32'h12345678};
        vecs[4] = '{0, 0, 32'h80,       32'h0,        0, 0, 0, 0, 32'hA5A5A5A5, 3, 0, 0, 1, 32'hA5A5A5A5};
        vecs[5] = '{0, 3, 32'hFFFC,     32'h0,        0, 0, 1, 3, 32'hC0FFEE01, 7, 0, 0, 2, 32'hC0FFEE01};
        vecs[6] = '{1, 1, 32'h100,      32'hCAFEF00D, 2, 2, 0, 0, 32'h0,        4, 3, 3, 0, 32'hC0FFEE01};
        vecs[7] = '{1, 1, 32'h104,      32'h0BADF00D, 1, 3, 0, 0, 32'h0,        5, 2, 4, 0, 32'hC0FFEE01};

        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; r_data_val = '0;

        // Reset values, including no grant while reset is held.
        repeat (2) tick();
        req_valid = '1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_valids",    64'({axi.AWVALID, axi.WVALID, axi.ARVALID, axi.RREADY}), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_addrs",     64'(axi.AWADDR | axi.ARADDR | axi.WDATA), 64'd0);
        chk("rst_rdata",     64'(rsp_rdata), 64'd0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        for (int n = 0; n < 8; n++) begin
            run_vec(n);
            tick();
        end

        // All requesters continuously pending after reset.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        aw_dly = 0; w_dly = 0;
        req_write = '1;
        for (int i = 0; i < int'(NR); i++) begin
            req_addr[i*AW +: AW]  = 32'h200 + 32'(i * 4);
            req_wdata[i*DW +: DW] = 32'(i);
        end
        req_valid = '1;
        #1;
        base = rsp_seen; ng = 0; prev = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            if (req_ready != '0) begin
                g = oh_idx(req_ready);
                chk($sformatf("rr_order%0d", ng), 64'(g), 64'(exp_rr[ng]));
                chk($sformatf("rr_done_before%0d", ng), 64'(rsp_seen - base), 64'(ng));
                if (ng > 0) chk($sformatf("rr_spacing%0d", ng), 64'(c - prev), 64'd2);
                prev = c;
                ng++;
            end
            tick();
        end
        chk("rr_grants", 64'(ng), 64'd5);
        req_valid = '0;
        repeat (4) tick();

        // Reset while a read waits for RVALID, then arbitration restarts from requester 0.
        req_write = '0;
        req_addr[1*AW +: AW] = 32'h30;
        ar_dly = 0; r_dly = 20;
        req_valid = 4'b0010;
        #1;
        wait_grant(20, g);
        chk("abort_grant", 64'(g), 64'd1);
        tick(); req_valid = '0;
        tick(); tick();
        chk("abort_rready_up", 64'(axi.RREADY), 64'd1);
        base = rsp_seen;
        rst = 1'b1;
        #1;
        chk("abort_valids", 64'({axi.ARVALID, axi.RREADY}), 64'd0);
        chk("abort_busy",   64'(busy), 64'd0);
        chk("abort_rsp",    64'(rsp_valid), 64'd0);
        r_dly = 0; aw_dly = 0; w_dly = 0;
        req_write = '1;
        req_valid = 4'b1001;
        tick(); tick();
        chk("abort_no_grant_in_rst", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1;
        wait_grant(20, g);
        chk("post_rst_grant", 64'(g), 64'd0);
        tick(); req_valid[0] = 1'b0;
        wait_grant(20, g);
        chk("post_rst_grant2", 64'(g), 64'd3);
        tick(); req_valid = 4'b1010;
        wait_grant(20, g);
        chk("sparse_grant1", 64'(g), 64'd1);
        tick(); req_valid = 4'b1000;
        wait_grant(20, g);
        chk("sparse_grant3", 64'(g), 64'd3);
        tick(); req_valid = '0;
        repeat (5) tick();
        chk("abort_rsp_total", 64'(rsp_seen - base), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end
endmodule
